seg_to_hex_capture: RTL

- Receive-side counterpart of the hex-to-7-segment encoder: snoops a multiplexed, active-low, common-anode 7-segment display bus and recovers the displayed hex digits.
- Qualifies each digit by stability, decodes the segment pattern back to a nibble and assembles a full multi-digit frame.
- Used in self-checking display paths and for board-level readback of what the display is actually showing.

---
 rtl/seg_to_hex_capture_if.sv | 22 ++
 rtl/seg_to_hex_capture.sv | 137 +++++++++++++
 2 files changed

// File: rtl/seg_to_hex_capture_if.sv
// rtl/seg_to_hex_capture_if.sv - display snoop bus and frame result bundle for seg_to_hex_capture
interface seg_to_hex_capture_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    sample_en;
    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   an_in;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   digit_err;
    logic                    frame_valid;
    logic                    timeout;

    modport master (
        output sample_en, seg_in, an_in,
        input  value, digit_err, frame_valid, timeout
    );

    modport slave (
        input  sample_en, seg_in, an_in,
        output value, digit_err, frame_valid, timeout
    );
endinterface

// File: rtl/seg_to_hex_capture.sv
// rtl/seg_to_hex_capture.sv - recovers hex digits from a multiplexed active-low 7-segment bus
// Optional frame timeout enabled by defining SEG_TIMEOUT_EN.
module seg_to_hex_capture #(
    parameter int NUM_DIGITS      = 4,
    parameter int STABLE_CYCLES   = 4,
    parameter int TIMEOUT_SAMPLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    seg_to_hex_capture_if.slave  bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

    logic [NUM_DIGITS-1:0]   seen;
    logic [NUM_DIGITS-1:0]   shadow_err;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [3:0]              stab_cnt;
    logic [NUM_DIGITS-1:0]   last_an;
    logic [6:0]              last_seg;
    logic                    frame_pend;

    logic [NUM_DIGITS-1:0]   an_low;
    logic                    selected;
    logic                    same;
    logic                    accept;
    logic [IDX_W-1:0]        idx;
    logic [3:0]              nib;
    logic                    bad;
    logic                    timeout_hit;
    logic [NUM_DIGITS-1:0]   seen_next;

    // Returns {undecodable, nibble}; patterns are g..a, active-low.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h40:   decode = 5'h00;
            7'h79:   decode = 5'h01;
            7'h24:   decode = 5'h02;
            7'h30:   decode = 5'h03;
            7'h19:   decode = 5'h04;
            7'h12:   decode = 5'h05;
            7'h02:   decode = 5'h06;
            7'h78:   decode = 5'h07;
            7'h00:   decode = 5'h08;
            7'h18:   decode = 5'h09;
            7'h08:   decode = 5'h0A;
            7'h03:   decode = 5'h0B;
            7'h46:   decode = 5'h0C;
            7'h21:   decode = 5'h0D;
            7'h06:   decode = 5'h0E;
            7'h0E:   decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

`ifdef SEG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_SAMPLES + 1);
    logic [TW-1:0] tcnt;
`endif

    always_comb begin
        an_low   = ~bus.an_in;
        selected = (an_low != '0) && ((an_low & (an_low - ONE)) == '0);
        idx      = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_low[i]) idx = IDX_W'(i);
        end
        same     = ({bus.an_in, bus.seg_in} == {last_an, last_seg});
        accept   = bus.sample_en && selected && same && (stab_cnt == 4'(STABLE_CYCLES - 1));
        {bad, nib} = decode(bus.seg_in);
`ifdef SEG_TIMEOUT_EN
        timeout_hit = !frame_pend && bus.sample_en && (seen != '0) &&
                      (tcnt == TW'(TIMEOUT_SAMPLES - 1));
`else
        timeout_hit = 1'b0;
`endif
        // An accept on the frame-complete or timeout edge seeds the next frame.
        seen_next = ((frame_pend || timeout_hit) ? '0 : seen) |
                    (accept ? (ONE << idx) : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seen            <= '0;
            shadow          <= '0;
            shadow_err      <= '0;
            stab_cnt        <= '0;
            last_an         <= '1;
            last_seg        <= 7'h7F;
            frame_pend      <= 1'b0;
            bus.value       <= '0;
            bus.digit_err   <= '0;
            bus.frame_valid <= 1'b0;
        end else begin
            bus.frame_valid <= 1'b0;
            if (frame_pend) begin
                bus.value       <= shadow;
                bus.digit_err   <= shadow_err;
                bus.frame_valid <= 1'b1;
            end
            frame_pend <= accept && (&seen_next);
            seen       <= seen_next;
            if (bus.sample_en) begin
                last_an  <= bus.an_in;
                last_seg <= bus.seg_in;
                if (!selected)
                    stab_cnt <= '0;
                else if (same) begin
                    if (stab_cnt != 4'(STABLE_CYCLES)) stab_cnt <= stab_cnt + 4'd1;
                end else
                    stab_cnt <= 4'd1;
            end
            if (accept) begin
                shadow[int'(idx)*4 +: 4] <= nib;
                shadow_err[idx]          <= bad;
            end
        end
    end

`ifdef SEG_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt        <= '0;
            bus.timeout <= 1'b0;
        end else begin
            bus.timeout <= timeout_hit;
            if (frame_pend || timeout_hit)
                tcnt <= '0;
            else if (bus.sample_en && (seen != '0))
                tcnt <= tcnt + TW'(1);
        end
    end
`else
    assign bus.timeout = 1'b0;
`endif

endmodule
